// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// Pure declarations: no latency, no flow control.
package fetch_pkg;

   typedef enum logic [1:0] {
      WAIT  = 2'd0,
      HOLD  = 2'd1,
      FAULT = 2'd2
   } fetch_state_e;

   localparam int unsigned WORD_BYTES      = 4;
   localparam logic [31:0] PC_ALIGN_MASK   = 32'hFFFF_FFFC;
   localparam logic [31:0] FETCH_COUNT_MAX = 32'hFFFF_FFFF;
   localparam int unsigned CNT_W           = 4;

   // Word index of a byte address compared against the memory depth in words.
   function automatic logic pc_out_of_range(input logic [31:0] pc, input logic [31:0] depth_words);
      return ({2'b00, pc[31:2]} >= depth_words);
   endfunction

endpackage

// File: rtl/fetch_wait_timer.sv
// Loadable down-counter timing the instruction-memory latency; done while cnt==1.
// Counts only when enabled; load has priority over counting; no handshake.
module fetch_wait_timer
   import fetch_pkg::*;
#(
   parameter int MEM_LAT = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic en,
   output logic done
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = CNT_W'(MEM_LAT);
      end else if (en) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= CNT_W'(MEM_LAT);
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/fetch_sequencer.sv
// PC owner and fetch controller: instruction valid MEM_LAT edges after im_addr changes, held until if_ready.
// Redirects override everything but reset; optional FETCH_STATS_EN macro enables the saturating fetch_count.
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          MEM_LAT  = 2,
   parameter int          IM_DEPTH = 256
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] im_addr,
   input  logic [31:0] im_data,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   output logic [31:0] if_pc_plus4,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        fetch_fault,
   output logic [31:0] fetch_count
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic         if_valid_q, if_valid_d;
   logic [31:0]  if_instr_q, if_instr_d;
   logic [31:0]  if_pc_q, if_pc_d;
   logic [31:0]  if_pc_plus4_q, if_pc_plus4_d;
   logic         fetch_fault_q, fetch_fault_d;

   logic         load_pc;
   logic [31:0]  load_val;
   logic         timer_done;

   fetch_wait_timer #(
      .MEM_LAT (MEM_LAT)
   ) u_timer (
      .clk   (clk),
      .reset (reset),
      .load  (load_pc),
      .en    (state_q == WAIT),
      .done  (timer_done)
   );

   // Any new PC (increment or redirect) funnels through one range-checked load path.
   assign load_pc  = redirect_valid || ((state_q == HOLD) && if_ready);
   assign load_val = redirect_valid ? (redirect_pc & PC_ALIGN_MASK)
                                    : (pc_q + 32'(WORD_BYTES));

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      if_valid_d    = if_valid_q;
      if_instr_d    = if_instr_q;
      if_pc_d       = if_pc_q;
      if_pc_plus4_d = if_pc_plus4_q;
      fetch_fault_d = fetch_fault_q;
      if (load_pc) begin
         pc_d       = load_val;
         if_valid_d = 1'b0;
         if (pc_out_of_range(load_val, 32'(IM_DEPTH))) begin
            state_d       = FAULT;
            fetch_fault_d = 1'b1;
         end else begin
            state_d       = WAIT;
            fetch_fault_d = 1'b0;
         end
      end else if ((state_q == WAIT) && timer_done) begin
         state_d       = HOLD;
         if_valid_d    = 1'b1;
         if_instr_d    = im_data;
         if_pc_d       = pc_q;
         if_pc_plus4_d = pc_q + 32'(WORD_BYTES);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= WAIT;
         pc_q          <= RESET_PC;
         if_valid_q    <= 1'b0;
         if_instr_q    <= 32'd0;
         if_pc_q       <= 32'd0;
         if_pc_plus4_q <= 32'd0;
         fetch_fault_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         if_valid_q    <= if_valid_d;
         if_instr_q    <= if_instr_d;
         if_pc_q       <= if_pc_d;
         if_pc_plus4_q <= if_pc_plus4_d;
         fetch_fault_q <= fetch_fault_d;
      end
   end

`ifdef FETCH_STATS_EN
   logic        transfer;
   logic [31:0] fetch_count_q, fetch_count_d;

   assign transfer = if_valid_q && if_ready && !redirect_valid;

   always_comb begin
      fetch_count_d = fetch_count_q;
      if (transfer && (fetch_count_q != FETCH_COUNT_MAX)) begin
         fetch_count_d = fetch_count_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_count_q <= 32'd0;
      end else begin
         fetch_count_q <= fetch_count_d;
      end
   end

   assign fetch_count = fetch_count_q;
`else
   assign fetch_count = 32'd0;
`endif

   assign im_addr     = pc_q;
   assign if_valid    = if_valid_q;
   assign if_instr    = if_instr_q;
   assign if_pc       = if_pc_q;
   assign if_pc_plus4 = if_pc_plus4_q;
   assign fetch_fault = fetch_fault_q;

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Instruction-fetch controller for the 5-stage pipeline. It owns the PC, drives the address input of the instruction memory, and waits a fixed memory latency. It then presents the fetched word to the IF/ID register over a valid/ready handshake. It also takes branch/jump redirects from the EX stage and flags fetches beyond the memory depth.

Parameters:
RESET_PC, 32'h0000_0000, byte address fetched first after reset; must be word aligned
MEM_LAT, 2, cycles from im_addr change to im_data valid; legal range 1..15
IM_DEPTH, 256, instruction memory depth in 32-bit words

Ports:
clk  in  1  clock; all state changes on the rising edge
reset  in  1  synchronous, active-high
im_addr  out  32  byte address to the instruction memory PC input
im_data  in  32  instruction word from the memory
if_valid  out  1  if_instr/if_pc hold a fetched instruction
if_ready  in  1  IF/ID accepts the instruction this cycle
if_instr  out  32  fetched instruction
if_pc  out  32  address of if_instr
if_pc_plus4  out  32  if_pc + 4, for link/branch computation
redirect_valid  in  1  branch/jump taken; flush and refetch
redirect_pc  in  32  redirect target byte address
fetch_fault  out  1  PC outside memory; fetch halted
fetch_count  out  32  accepted-instruction count (see Optional Feature)

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port named reset.
- Reset values (next edge with reset=1, from any state):
  - pc=RESET_PC, im_addr=RESET_PC
  - if_valid=0, if_instr=0, if_pc=0, if_pc_plus4=0
  - fetch_fault=0, fetch_count=0
  - state=WAIT, cnt=MEM_LAT
- States: WAIT, HOLD, FAULT. Internal cnt is 4 bits wide.
- WAIT:
  - im_addr is held at pc.
  - cnt decrements each edge.
  - On the edge where cnt==1: if_instr<=im_data, if_pc<=pc, if_pc_plus4<=pc+4, if_valid<=1, go to HOLD.
  - First if_valid is therefore MEM_LAT edges after im_addr changes.
- HOLD:
  - if_valid=1; if_instr, if_pc and im_addr are stable.
  - if_ready=0: remain in HOLD indefinitely.
  - if_ready=1 at an edge: transfer occurs. pc<=pc+4, im_addr<=pc+4, if_valid<=0, cnt<=MEM_LAT, go to WAIT.
  - Throughput: one instruction per MEM_LAT+1 cycles.
- Range check:
  - Before any new pc is loaded (increment or redirect), check pc>>2 >= IM_DEPTH.
  - Out of range: go to FAULT, fetch_fault<=1, if_valid<=0, im_addr<=new pc.
- FAULT:
  - Outputs hold; if_ready is ignored.
  - Exit only via reset or an in-range redirect.
- Redirect (highest priority below reset, any state):
  - pc and im_addr <= {redirect_pc[31:2],2'b00}; low two bits are forced to 0.
  - if_valid<=0, fetch_fault<=0, cnt<=MEM_LAT, go to WAIT (or FAULT if out of range).
- redirect_valid and if_ready both high in HOLD: redirect wins. No transfer occurs, no pc+4, fetch_count is unchanged. The IF/ID register is flushed by the same redirect.
- Arithmetic: pc+4 is 32-bit modulo. A wrap past 0xFFFF_FFFC reaches 0 only if IM_DEPTH covers it; otherwise FAULT is hit first.

Optional Feature:
FETCH_STATS_EN
- Defined: fetch_count increments by 1 on every transfer (if_valid & if_ready & ~redirect_valid), saturating at 32'hFFFF_FFFF. Cleared by reset only.
- Undefined: no counter logic; fetch_count is tied to 0. The port list is unchanged.

Decomposition:
- Shared package fetch_pkg:
  - state encoding (WAIT, HOLD, FAULT)
  - WORD_BYTES=4
  - PC_ALIGN_MASK=32'hFFFF_FFFC
  - count saturation constant
- One natural sub-module, fetch_wait_timer: loadable down-counter that loads MEM_LAT and flags done at cnt==1. All other logic stays in fetch_sequencer.

Test Plan:
- Defaults, reset released, if_ready=1 constant, memory preloaded:
  - im_addr=0x0; if_valid rises 2 edges later with if_instr=0x8c010004, if_pc=0, if_pc_plus4=4.
  - Next im_addr=0x4 with if_instr=0x8c02000c; the sequence repeats every 3 cycles.
- if_ready=0 for 5 cycles in HOLD at pc=0x8 -> if_instr=0x8c030014, if_pc=0x8 and im_addr=0x8 stable throughout. Raising if_ready gives one transfer, then im_addr=0xC.
- redirect_valid with redirect_pc=0x4C during WAIT -> next edge im_addr=0x4C, if_valid=0. After 2 edges if_valid=1 and if_pc=0x4C.
- redirect_pc=0x2E coincident with if_ready=1 in HOLD -> im_addr=0x2C, no pc+4. With FETCH_STATS_EN, fetch_count is unchanged.
- Out of range: redirect_pc=0x400 (IM_DEPTH=256) -> fetch_fault=1, if_valid=0, if_ready ignored. A later redirect_pc=0x8 clears fetch_fault and resumes at 0x8.
- reset asserted for one cycle while in HOLD with if_ready=0 -> next edge all outputs at reset values and im_addr=RESET_PC; fetch restarts normally.
